// File: rtl/point_double_seq.sv
// Projective point doubling over GF(P) with one shared modular multiplier; done 14 cycles after start is sampled.
// No backpressure: start is honoured only in IDLE, results are held until the next done.
module point_double_seq #(
   parameter int N = 8,
   parameter int P = 251,
   parameter int A = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] X1,
   input  logic [N-1:0] Y1,
   input  logic [N-1:0] Z1,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] X2,
   output logic [N-1:0] Y2,
   output logic [N-1:0] Z2
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [N-1:0]   PN    = N'(P);
   localparam logic [N:0]     PE    = (N+1)'(P);
   localparam logic [2*N-1:0] PP    = (2*N)'(P);
   localparam logic [N-1:0]   A_C   = N'(A);
   localparam logic [3:0]     LAST  = 4'd12;

   function automatic logic [N-1:0] add_m(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= PE) ? N'(s - PE) : N'(s);
   endfunction

   function automatic logic [N-1:0] sub_m(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0] d;
      if (a >= b) d = {1'b0, a} - {1'b0, b};
      else        d = {1'b0, a} + PE - {1'b0, b};
      return N'(d);
   endfunction

   function automatic logic [N-1:0] mul_m(input logic [N-1:0] a, input logic [N-1:0] b);
      return N'(((2*N)'(a) * (2*N)'(b)) % PP);
   endfunction

   function automatic logic [N-1:0] dbl_m(input logic [N-1:0] a);
      return add_m(a, a);
   endfunction

   function automatic logic [N-1:0] mul8_m(input logic [N-1:0] a);
      return dbl_m(dbl_m(dbl_m(a)));
   endfunction

   state_t       state_q, state_d;
   logic [3:0]   step;
   logic [N-1:0] xr, yr, zr;
   logic [N-1:0] xx, zz, w, s, ys, bv, h, hs, yy, ss, yyss, sss;
   logic [N-1:0] op_a, op_b, prod;
   logic [N-1:0] x2_q, y2_q, z2_q;
   logic         inf;

   assign inf  = (zr == '0);
   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);
   assign X2   = x2_q;
   assign Y2   = y2_q;
   assign Z2   = z2_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (step == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand schedule for the single multiplier, one product per CALC cycle.
   always_comb begin
      op_a = '0;
      op_b = '0;
      case (step)
         4'd0:    begin op_a = xr;  op_b = xr;  end
         4'd1:    begin op_a = zr;  op_b = zr;  end
         4'd2:    begin op_a = A_C; op_b = zz;  end
         4'd3:    begin op_a = yr;  op_b = zr;  end
         4'd4:    begin op_a = yr;  op_b = s;   end
         4'd5:    begin op_a = xr;  op_b = ys;  end
         4'd6:    begin op_a = w;   op_b = w;   end
         4'd7:    begin op_a = h;   op_b = s;   end
         4'd8:    begin op_a = yr;  op_b = yr;  end
         4'd9:    begin op_a = s;   op_b = s;   end
         4'd10:   begin op_a = yy;  op_b = ss;  end
         4'd11:   begin op_a = s;   op_b = ss;  end
         4'd12:   begin op_a = w;   op_b = sub_m(dbl_m(dbl_m(bv)), h); end
         default: begin op_a = '0;  op_b = '0;  end
      endcase
      prod = mul_m(op_a, op_b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step <= '0;
         xr   <= '0;  yr <= '0;  zr <= '0;
         xx   <= '0;  zz <= '0;  w  <= '0;  s  <= '0;
         ys   <= '0;  bv <= '0;  h  <= '0;  hs <= '0;
         yy   <= '0;  ss <= '0;  yyss <= '0;  sss <= '0;
         x2_q <= '0;
         y2_q <= N'(1);
         z2_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  xr   <= X1 % PN;
                  yr   <= Y1 % PN;
                  zr   <= Z1 % PN;
                  step <= '0;
               end
            end
            CALC: begin
               step <= step + 4'd1;
               case (step)
                  4'd0:  xx   <= prod;
                  4'd1:  zz   <= prod;
                  4'd2:  w    <= add_m(prod, add_m(xx, dbl_m(xx)));
                  4'd3:  s    <= prod;
                  4'd4:  ys   <= prod;
                  4'd5:  bv   <= prod;
                  4'd6:  h    <= sub_m(prod, mul8_m(bv));
                  4'd7:  hs   <= prod;
                  4'd8:  yy   <= prod;
                  4'd9:  ss   <= prod;
                  4'd10: yyss <= prod;
                  4'd11: sss  <= prod;
                  4'd12: begin
                     // Z==0 input is the point at infinity; its doubling is itself.
                     x2_q <= inf ? '0    : dbl_m(hs);
                     y2_q <= inf ? N'(1) : sub_m(prod, mul8_m(yyss));
                     z2_q <= inf ? '0    : mul8_m(sss);
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_point_double_seq.sv
// Bench for point_double_seq: small-field directed vectors and corner sequences, large-field random vs formula model.
module tb_point_double_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_s, busy_s, done_s;
   logic [2:0] x1_s, y1_s, z1_s, x2_s, y2_s, z2_s;
   logic       start_l, busy_l, done_l;
   logic [7:0] x1_l, y1_l, z1_l, x2_l, y2_l, z2_l;

   point_double_seq #(.N(3), .P(7), .A(1)) dut_s (
      .clk(clk), .rst(rst), .start(start_s),
      .X1(x1_s), .Y1(y1_s), .Z1(z1_s),
      .busy(busy_s), .done(done_s),
      .X2(x2_s), .Y2(y2_s), .Z2(z2_s)
   );

   point_double_seq #(.N(8), .P(251), .A(1)) dut_l (
      .clk(clk), .rst(rst), .start(start_l),
      .X1(x1_l), .Y1(y1_l), .Z1(z1_l),
      .busy(busy_l), .done(done_l),
      .X2(x2_l), .Y2(y2_l), .Z2(z2_l)
   );

   typedef struct {
      int x, y, z;
      int ex, ey, ez;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic longint md(input longint v, input longint p);
      return ((v % p) + p) % p;
   endfunction

   // Doubling straight from the curve formulas on integers.
   function automatic void model(input int p, input int a, input int x, input int y, input int z,
                                 output int rx, output int ry, output int rz);
      longint xv, yv, zv, w, s, bb, h;
      xv = x % p; yv = y % p; zv = z % p;
      if (zv == 0) begin
         rx = 0; ry = 1; rz = 0;
      end else begin
         w  = md(a * zv * zv + 3 * xv * xv, p);
         s  = md(yv * zv, p);
         bb = md(xv * yv * s, p);
         h  = md(w * w - 8 * bb, p);
         rx = int'(md(2 * h * s, p));
         ry = int'(md(w * (4 * bb - h) - 8 * yv * yv * s * s, p));
         rz = int'(md(8 * s * s * s, p));
      end
   endfunction

   task automatic op_s(input int x, input int y, input int z,
                       output int lat, output logic [8:0] res, output logic bsy);
      logic [31:0] xv, yv, zv;
      xv = x; yv = y; zv = z;
      @(negedge clk);
      x1_s = xv[2:0]; y1_s = yv[2:0]; z1_s = zv[2:0];
      start_s = 1'b1;
      @(posedge clk);
      #1 start_s = 1'b0;
      lat = -1;
      bsy = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done_s) begin
            lat = c;
            bsy = busy_s;
            break;
         end
      end
      res = {x2_s, y2_s, z2_s};
   endtask

   task automatic op_l(input int x, input int y, input int z, output int lat, output logic [23:0] res);
      logic [31:0] xv, yv, zv;
      xv = x; yv = y; zv = z;
      @(negedge clk);
      x1_l = xv[7:0]; y1_l = yv[7:0]; z1_l = zv[7:0];
      start_l = 1'b1;
      @(posedge clk);
      #1 start_l = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done_l) begin
            lat = c;
            break;
         end
      end
      res = {x2_l, y2_l, z2_l};
   endtask

   function automatic logic [8:0] pk3(input int a, input int b, input int c);
      logic [31:0] av, bv, cv;
      av = a; bv = b; cv = c;
      return {av[2:0], bv[2:0], cv[2:0]};
   endfunction

   initial begin
      vec_t       tbl[4];
      int         lat, first, second, npulse, rx, ry, rz;
      logic [8:0] res, r1, r2;
      logic [23:0] resl;
      logic       bsy, prev, consec, held_ok, seen;

      tbl[0] = '{x:2, y:1, z:1, ex:5, ey:4, ez:1};
      tbl[1] = '{x:3, y:2, z:1, ex:1, ey:5, ez:1};
      tbl[2] = '{x:2, y:0, z:1, ex:0, ey:1, ez:0};
      tbl[3] = '{x:5, y:3, z:0, ex:0, ey:1, ez:0};

      rst = 1'b1;
      start_s = 1'b0; x1_s = '0; y1_s = '0; z1_s = '0;
      start_l = 1'b0; x1_l = '0; y1_l = '0; z1_l = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_small", {60'd0, busy_s, done_s, 2'b00} | 64'({x2_s, y2_s, z2_s}) << 4,
            64'(pk3(0, 1, 0)) << 4);
      check("reset_large", {busy_l, done_l, x2_l, y2_l, z2_l}, {2'b00, 8'd0, 8'd1, 8'd0});
      rst = 1'b0;

      // Directed vectors; vector 1 is followed by the idle hold check.
      for (int i = 0; i < 4; i++) begin
         op_s(tbl[i].x, tbl[i].y, tbl[i].z, lat, res, bsy);
         check($sformatf("latency_%0d", i), lat, 14);
         check($sformatf("result_%0d", i), res, pk3(tbl[i].ex, tbl[i].ey, tbl[i].ez));
         check($sformatf("busy_at_done_%0d", i), bsy, 1'b0);
         if (i == 1) begin
            held_ok = 1'b1;
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (done_s || busy_s || {x2_s, y2_s, z2_s} != pk3(1, 5, 1)) held_ok = 1'b0;
            end
            check("hold_20_idle", held_ok, 1'b1);
         end
      end

      // start held 40 cycles, inputs changed mid-CALC of the first op.
      @(negedge clk);
      x1_s = 3'd2; y1_s = 3'd1; z1_s = 3'd1; start_s = 1'b1;
      first = -1; second = -1; npulse = 0; prev = 1'b0; consec = 1'b0;
      r1 = '0; r2 = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 3) begin x1_s = 3'd3; y1_s = 3'd2; z1_s = 3'd1; end
         if (done_s) begin
            npulse++;
            if (prev) consec = 1'b1;
            if (npulse == 1) begin first = c; r1 = {x2_s, y2_s, z2_s}; end
            else if (npulse == 2) begin second = c; r2 = {x2_s, y2_s, z2_s}; end
         end
         prev = done_s;
      end
      start_s = 1'b0;
      check("held_start_pulses", npulse, 2);
      check("held_start_first_at", first, 14);
      check("held_start_period", second - first, 15);
      check("held_start_r1", r1, pk3(5, 4, 1));
      check("held_start_r2", r2, pk3(1, 5, 1));
      check("held_start_no_consec", consec, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         if (done_s) seen = 1'b1;
      end
      check("third_op_drains", seen, 1'b1);
      @(negedge clk);

      // Reset while CALC is on step 6.
      x1_s = 3'd2; y1_s = 3'd1; z1_s = 3'd1; start_s = 1'b1;
      @(posedge clk);
      #1 start_s = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_state", {busy_s, done_s, x2_s, y2_s, z2_s}, {2'b00, pk3(0, 1, 0)});
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done_s || busy_s) seen = 1'b1;
      end
      check("abort_no_done", seen, 1'b0);
      op_s(3, 2, 1, lat, res, bsy);
      check("after_abort_latency", lat, 14);
      check("after_abort_result", res, pk3(1, 5, 1));

      // Random vectors on the 8-bit field, including unreduced inputs and Z==0.
      for (int i = 0; i < 500; i++) begin
         int x, y, z;
         x = $urandom_range(0, 255);
         y = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
         z = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
         model(251, 1, x, y, z, rx, ry, rz);
         op_l(x, y, z, lat, resl);
         if (lat != 14) check($sformatf("rand_latency_%0d", i), lat, 14);
         check($sformatf("rand_%0d(%0d,%0d,%0d)", i, x, y, z), resl,
               {rx[7:0], ry[7:0], rz[7:0]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
